// File: rtl/tmrx_err_pkg.sv
// Shared types, defaults and helpers for the tmrx error collector.
package tmrx_err_pkg;

  localparam int unsigned DEF_NUM_SRC      = 4;
  localparam int unsigned DEF_CNT_W        = 8;
  localparam int unsigned DEF_TS_W         = 16;
  localparam int unsigned DEF_FATAL_THRESH = 3;

  // Collector control states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REPORT = 2'd1,
    ST_FATAL  = 2'd2
  } state_e;

  // Index width for n sources; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // a + b clamped to max; the carry bit keeps the compare exact.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max}) ? max : sum[31:0];
  endfunction

endpackage

// File: rtl/tmrx_err_prio_enc.sv
// Lowest-index find-first-set over a bit vector, plus an any-bit flag.
module tmrx_err_prio_enc #(
  parameter int unsigned W     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [W-1:0]     vec,
  output logic [IDX_W-1:0] idx_c,
  output logic             any_c
);

  // Scan from the top down so the lowest set bit is written last and wins.
  always_comb begin
    idx_c = '0;
    any_c = |vec;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (vec[i]) idx_c = IDX_W'(i);
    end
  end

endmodule

// File: rtl/tmrx_err_collector.sv
// Collects tmrx error sink lines: sticky status, saturating event count,
// serialised per-source reports over valid/ready, and fatal escalation.
// Optional: define TMRX_ERR_TIMESTAMP_EN to add per-source capture
// timestamps and the rpt_ts_o port.
module tmrx_err_collector
  import tmrx_err_pkg::*;
#(
  parameter int unsigned NUM_SRC      = DEF_NUM_SRC,
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter int unsigned FATAL_THRESH = DEF_FATAL_THRESH,
  parameter int unsigned TS_W         = DEF_TS_W,
  localparam int unsigned SRC_W       = idx_width(NUM_SRC)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_SRC-1:0] err_i,
  input  logic               clear_i,
  output logic [NUM_SRC-1:0] sticky_o,
  output logic [CNT_W-1:0]   count_o,
  output logic               irq_o,
  output logic               ovf_o,
  output logic               fatal_o,
  output logic               rpt_valid_o,
  input  logic               rpt_ready_i,
  output logic [SRC_W-1:0]   rpt_src_o
`ifdef TMRX_ERR_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]    rpt_ts_o
`endif
);

  localparam int unsigned CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  // Reject configurations the counter or threshold cannot represent.
  if (NUM_SRC < 1 || CNT_W < 1 || CNT_W > 31 || TS_W < 1 ||
      FATAL_THRESH < 1 || FATAL_THRESH > CNT_MAX) begin : g_param_err
    $error("tmrx_err_collector: illegal parameter combination");
  end

  logic [NUM_SRC-1:0] err_q;
  logic [NUM_SRC-1:0] evt_q;
  logic [NUM_SRC-1:0] pending_q;
  logic [NUM_SRC-1:0] pend_base;
  logic [NUM_SRC-1:0] pend_d;
  logic [NUM_SRC-1:0] sticky_d;
  logic [CNT_W-1:0]   cnt_d;
  logic [31:0]        evt_cnt;
  logic               ovf_d;
  logic               hs;

  state_e             state_q;
  state_e             state_d;
  logic               valid_d;
  logic               fatal_d;
  logic [SRC_W-1:0]   src_d;
  logic [SRC_W-1:0]   pend_idx;
  logic               pend_any;

  assign hs = rpt_valid_o & rpt_ready_i;

  tmrx_err_prio_enc #(
    .W     (NUM_SRC),
    .IDX_W (SRC_W)
  ) u_prio (
    .vec   (pending_q),
    .idx_c (pend_idx),
    .any_c (pend_any)
  );

  // Status update: clear (or handshake retirement) first, then this cycle's events.
  always_comb begin
    evt_cnt   = '0;
    pend_base = pending_q;
    sticky_d  = sticky_o;
    cnt_d     = count_o;
    ovf_d     = ovf_o;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      evt_cnt = evt_cnt + 32'(evt_q[i]);
    end
    if (clear_i) begin
      pend_base = '0;
      sticky_d  = '0;
      cnt_d     = '0;
      ovf_d     = 1'b0;
    end else if (hs) begin
      for (int i = 0; i < int'(NUM_SRC); i++) begin
        if (rpt_src_o == SRC_W'(i)) pend_base[i] = 1'b0;
      end
    end
    ovf_d    = ovf_d | (|(evt_q & pend_base));
    sticky_d = sticky_d | evt_q;
    pend_d   = pend_base | evt_q;
    cnt_d    = CNT_W'(sat_add(32'(cnt_d), evt_cnt, CNT_MAX));
  end

  // Control: fatal check and report selection happen only from IDLE.
  always_comb begin
    state_d = state_q;
    valid_d = 1'b0;
    fatal_d = 1'b0;
    src_d   = rpt_src_o;
    unique case (state_q)
      ST_IDLE: begin
        if (clear_i) begin
          state_d = ST_IDLE;
        end else if (32'(count_o) >= FATAL_THRESH) begin
          state_d = ST_FATAL;
          fatal_d = 1'b1;
        end else if (pend_any) begin
          state_d = ST_REPORT;
          valid_d = 1'b1;
          src_d   = pend_idx;
        end
      end
      ST_REPORT: begin
        if (clear_i || hs) begin
          state_d = ST_IDLE;
        end else begin
          valid_d = 1'b1;
        end
      end
      ST_FATAL: begin
        if (clear_i) begin
          state_d = ST_IDLE;
        end else begin
          fatal_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state and registered report/fatal outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      rpt_valid_o <= 1'b0;
      rpt_src_o   <= '0;
      fatal_o     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rpt_valid_o <= valid_d;
      rpt_src_o   <= src_d;
      fatal_o     <= fatal_d;
    end
  end

  // Edge detect pipeline and sticky/count/pending/overflow state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q     <= '0;
      evt_q     <= '0;
      pending_q <= '0;
      sticky_o  <= '0;
      count_o   <= '0;
      ovf_o     <= 1'b0;
      irq_o     <= 1'b0;
    end else begin
      err_q     <= err_i;
      evt_q     <= err_i & ~err_q;
      pending_q <= pend_d;
      sticky_o  <= sticky_d;
      count_o   <= cnt_d;
      ovf_o     <= ovf_d;
      irq_o     <= |sticky_o;
    end
  end

`ifdef TMRX_ERR_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt_q;
  logic [TS_W-1:0] ts_q [NUM_SRC];

  // Free-running stamp; a source's stamp is taken only when its pending bit rises from 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ts_cnt_q <= '0;
      rpt_ts_o <= '0;
      for (int i = 0; i < int'(NUM_SRC); i++) ts_q[i] <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + TS_W'(1);
      for (int i = 0; i < int'(NUM_SRC); i++) begin
        if (evt_q[i] && !pend_base[i]) ts_q[i] <= ts_cnt_q;
      end
      if (state_q == ST_IDLE && state_d == ST_REPORT) rpt_ts_o <= ts_q[pend_idx];
    end
  end
`endif

endmodule

// File: tb/tb_tmrx_err_collector.sv
// Directed bench for tmrx_err_collector: three instances share stimulus
// (default threshold 3, threshold 4, and a 2-bit saturating counter).
module tb_tmrx_err_collector;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       ready;
  logic [3:0] err;

  logic [3:0] a_sticky, b_sticky, c_sticky;
  logic [7:0] a_count, b_count;
  logic [1:0] c_count;
  logic       a_irq, a_ovf, a_fatal, a_valid;
  logic       b_irq, b_ovf, b_fatal, b_valid;
  logic       c_irq, c_ovf, c_fatal, c_valid;
  logic [1:0] a_src, b_src, c_src;
`ifdef TMRX_ERR_TIMESTAMP_EN
  logic [15:0] a_ts, b_ts, c_ts;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  tmrx_err_collector #(.NUM_SRC(4), .CNT_W(8), .FATAL_THRESH(3), .TS_W(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .err_i(err), .clear_i(clear),
    .sticky_o(a_sticky), .count_o(a_count), .irq_o(a_irq), .ovf_o(a_ovf),
    .fatal_o(a_fatal), .rpt_valid_o(a_valid), .rpt_ready_i(ready), .rpt_src_o(a_src)
`ifdef TMRX_ERR_TIMESTAMP_EN
    , .rpt_ts_o(a_ts)
`endif
  );

  tmrx_err_collector #(.NUM_SRC(4), .CNT_W(8), .FATAL_THRESH(4), .TS_W(16)) dut_b (
    .clk_i(clk), .rst_i(rst), .err_i(err), .clear_i(clear),
    .sticky_o(b_sticky), .count_o(b_count), .irq_o(b_irq), .ovf_o(b_ovf),
    .fatal_o(b_fatal), .rpt_valid_o(b_valid), .rpt_ready_i(ready), .rpt_src_o(b_src)
`ifdef TMRX_ERR_TIMESTAMP_EN
    , .rpt_ts_o(b_ts)
`endif
  );

  tmrx_err_collector #(.NUM_SRC(4), .CNT_W(2), .FATAL_THRESH(3), .TS_W(16)) dut_c (
    .clk_i(clk), .rst_i(rst), .err_i(err), .clear_i(clear),
    .sticky_o(c_sticky), .count_o(c_count), .irq_o(c_irq), .ovf_o(c_ovf),
    .fatal_o(c_fatal), .rpt_valid_o(c_valid), .rpt_ready_i(ready), .rpt_src_o(c_src)
`ifdef TMRX_ERR_TIMESTAMP_EN
    , .rpt_ts_o(c_ts)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    err   = 4'b0000;
    clear = 1'b0;
    ready = 1'b0;
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; err = 4'b0000; clear = 1'b0; ready = 1'b0;
    step(2);
    check("rst_sticky", 32'(a_sticky), 32'h0);
    check("rst_count",  32'(a_count),  32'h0);
    check("rst_flags",  32'({a_irq, a_ovf, a_fatal, a_valid}), 32'h0);
    check("rst_src",    32'(a_src),    32'h0);
    rst = 1'b0;

    // Single event held high.
    do_reset();
    err = 4'b0010;
    step(1);
    check("single_sticky_early", 32'(a_sticky), 32'h0);
    step(1);
    check("single_sticky", 32'(a_sticky), 32'h2);
    check("single_count",  32'(a_count),  32'h1);
    check("single_irq_lag", 32'(a_irq),   32'h0);
    check("single_valid_lag", 32'(a_valid), 32'h0);
    step(1);
    check("single_irq",   32'(a_irq),   32'h1);
    check("single_valid", 32'(a_valid), 32'h1);
    check("single_src",   32'(a_src),   32'h1);
    ready = 1'b1;
    step(1);
    check("single_accept", 32'(a_valid), 32'h0);
    step(3);
    check("single_held_valid", 32'(a_valid), 32'h0);
    check("single_held_count", 32'(a_count), 32'h1);
    err = 4'b0000; ready = 1'b0;

    // Simultaneous events 0000 -> 1011.
    do_reset();
    ready = 1'b1;
    err   = 4'b1011;
    step(2);
    check("sim_count",  32'(b_count),  32'h3);
    check("sim_sticky", 32'(b_sticky), 32'hb);
    step(1);
    check("sim_r0", 32'({b_valid, b_src}), 32'h4);
    check("sim_fatal_thr3", 32'(a_fatal), 32'h1);
    step(1);
    check("sim_gap0", 32'(b_valid), 32'h0);
    step(1);
    check("sim_r1", 32'({b_valid, b_src}), 32'h5);
    step(1);
    check("sim_gap1", 32'(b_valid), 32'h0);
    step(1);
    check("sim_r3", 32'({b_valid, b_src}), 32'h7);
    step(1);
    check("sim_done",  32'(b_valid), 32'h0);
    check("sim_fatal", 32'(b_fatal), 32'h0);
    step(2);
    check("sim_idle", 32'(b_valid), 32'h0);
    err = 4'b0000; ready = 1'b0;

    // Backpressure and overflow on src 2.
    do_reset();
    err = 4'b0100; step(1);
    err = 4'b0000; step(1);
    err = 4'b0100; step(1);
    check("bp_first", 32'({a_valid, a_src}), 32'h6);
    err = 4'b0000; step(1);
    check("bp_ovf",   32'(a_ovf),   32'h1);
    check("bp_count", 32'(a_count), 32'h2);
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("bp_stall", 32'({a_valid, a_src}), 32'h6);
    end
    ready = 1'b1;
    step(1);
    check("bp_accept", 32'(a_valid), 32'h0);
    step(2);
    check("bp_one_only", 32'(a_valid), 32'h0);
    check("bp_ovf_sticky", 32'(a_ovf), 32'h1);
    ready = 1'b0;

    // Fatal escalation after in-flight report.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      err = 4'b0001; step(1);
      err = 4'b0000; step(1);
    end
    check("fat_count",    32'(a_count), 32'h3);
    check("fat_inflight", 32'({a_fatal, a_valid, a_src}), 32'h4);
    ready = 1'b1;
    step(1);
    check("fat_accept", 32'({a_fatal, a_valid}), 32'h0);
    step(1);
    check("fat_enter", 32'({a_fatal, a_valid}), 32'h2);
    for (int k = 0; k < 2; k++) begin
      err = 4'b0001; step(1);
      check("fat_novalid", 32'(a_valid), 32'h0);
      err = 4'b0000; step(1);
    end
    check("fat_count5", 32'(a_count), 32'h5);
    check("fat_hold",   32'({a_fatal, a_valid}), 32'h2);
    clear = 1'b1;
    step(1);
    check("fat_clr_fatal",  32'(a_fatal),  32'h0);
    check("fat_clr_count",  32'(a_count),  32'h0);
    check("fat_clr_sticky", 32'(a_sticky), 32'h0);
    clear = 1'b0;
    step(1);
    check("fat_idle", 32'({a_fatal, a_valid}), 32'h0);
    ready = 1'b0;

    // Clear coinciding with an event; also withdraws an in-flight report.
    do_reset();
    err = 4'b0001; step(1);
    err = 4'b0000; step(1);
    err = 4'b1000; step(1);
    check("clr_inflight", 32'({a_valid, a_src}), 32'h4);
    clear = 1'b1;
    step(1);
    check("clr_sticky",   32'(a_sticky), 32'h8);
    check("clr_count",    32'(a_count),  32'h1);
    check("clr_withdraw", 32'(a_valid),  32'h0);
    check("clr_ovf",      32'(a_ovf),    32'h0);
    clear = 1'b0;
    step(1);
    check("clr_new_rpt", 32'({a_valid, a_src}), 32'h7);
    err = 4'b0000;

    // Saturation on the 2-bit counter, then reset mid-run.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      err = 4'b0010; step(1);
      err = 4'b0000; step(1);
    end
    check("sat_at3", 32'(c_count), 32'h3);
    for (int k = 0; k < 2; k++) begin
      err = 4'b0010; step(1);
      err = 4'b0000; step(1);
    end
    check("sat_hold", 32'(c_count), 32'h3);
    check("sat_wide_count", 32'(a_count), 32'h5);
    rst = 1'b1;
    step(1);
    check("sat_rst_c", 32'({c_count, c_sticky, c_irq, c_ovf, c_fatal, c_valid, c_src}), 32'h0);
    check("sat_rst_a", 32'({a_count, a_sticky, a_irq, a_ovf, a_fatal, a_valid}), 32'h0);
    rst = 1'b0;
    step(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
